// File: rtl/matrix_mult_seq.sv
// Sequential signed matrix multiplier: O = A*B or O += A*B, one MAC per enabled cycle.
// Operands are snapshotted at start; each finished element is streamed with its index.
module matrix_mult_seq #(
    parameter int unsigned AROWS     = 3,
    parameter int unsigned ACOLUMNS  = 3,
    parameter int unsigned BCOLUMNS  = 3,
    parameter int unsigned WIDTH_BIT = 32,
    parameter int unsigned ACC_WIDTH = 2*WIDTH_BIT + $clog2(ACOLUMNS) + 1,
    localparam int unsigned ROW_W    = (AROWS > 1) ? $clog2(AROWS) : 1,
    localparam int unsigned COL_W    = (BCOLUMNS > 1) ? $clog2(BCOLUMNS) : 1
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        ena,
    input  logic                        start,
    input  logic                        accumulate,
    input  logic                        sat_mode,
    input  logic signed [WIDTH_BIT-1:0] MatrixA [AROWS][ACOLUMNS],
    input  logic signed [WIDTH_BIT-1:0] MatrixB [ACOLUMNS][BCOLUMNS],
    output logic signed [WIDTH_BIT-1:0] MatrixO [AROWS][BCOLUMNS],
    output logic                        busy,
    output logic                        done,
    output logic                        elem_valid,
    output logic [ROW_W-1:0]            elem_row,
    output logic [COL_W-1:0]            elem_col,
    output logic signed [WIDTH_BIT-1:0] elem_data,
    output logic                        overflow
);

    localparam int unsigned K_W    = (ACOLUMNS > 1) ? $clog2(ACOLUMNS) : 1;
    localparam int unsigned PROD_W = 2*WIDTH_BIT;
    localparam int unsigned HI_W   = ACC_WIDTH - WIDTH_BIT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic signed [WIDTH_BIT-1:0] a_q [AROWS][ACOLUMNS];
    logic signed [WIDTH_BIT-1:0] b_q [ACOLUMNS][BCOLUMNS];
    logic                        accum_q;
    logic                        sat_q;
    logic [ROW_W-1:0]            i_q;
    logic [COL_W-1:0]            j_q;
    logic [K_W-1:0]              k_q;
    logic signed [ACC_WIDTH-1:0] acc_q;

    logic                        start_fire_c;
    logic                        last_k_c;
    logic                        last_j_c;
    logic                        last_elem_c;
    logic signed [WIDTH_BIT-1:0] a_el_c;
    logic signed [WIDTH_BIT-1:0] b_el_c;
    logic signed [PROD_W-1:0]    prod_c;
    logic signed [ACC_WIDTH-1:0] acc_next_c;
    logic signed [ACC_WIDTH-1:0] o_ext_c;
    logic signed [ACC_WIDTH-1:0] r_c;
    logic [HI_W-1:0]             hi_c;
    logic                        ovf_c;
    logic signed [WIDTH_BIT-1:0] elem_c;

    // State register
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic and control strobes
    always_comb begin
        state_d      = state_q;
        start_fire_c = 1'b0;
        last_k_c     = (k_q == K_W'(ACOLUMNS - 1));
        last_j_c     = (j_q == COL_W'(BCOLUMNS - 1));
        last_elem_c  = last_k_c && last_j_c && (i_q == ROW_W'(AROWS - 1));
        if (ena) begin
            case (state_q)
                IDLE: if (start) begin
                    start_fire_c = 1'b1;
                    state_d      = RUN;
                end
                RUN:     if (last_elem_c) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // MAC, final add of the previous O element, and saturate/wrap of the result
    always_comb begin
        a_el_c     = a_q[i_q][k_q];
        b_el_c     = b_q[k_q][j_q];
        prod_c     = PROD_W'(a_el_c) * PROD_W'(b_el_c);
        acc_next_c = acc_q + ACC_WIDTH'(prod_c);
        o_ext_c    = accum_q ? ACC_WIDTH'(MatrixO[i_q][j_q]) : '0;
        r_c        = acc_next_c + o_ext_c;
        hi_c       = r_c[ACC_WIDTH-1:WIDTH_BIT-1];
        ovf_c      = !((&hi_c) || !(|hi_c));
        elem_c     = r_c[WIDTH_BIT-1:0];
        if (ovf_c && sat_q) begin
            elem_c = r_c[ACC_WIDTH-1] ? {1'b1, {(WIDTH_BIT-1){1'b0}}}
                                      : {1'b0, {(WIDTH_BIT-1){1'b1}}};
        end
    end

    // Datapath and registered outputs; everything holds while ena is low
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < int'(AROWS); r++) begin
                for (int c = 0; c < int'(ACOLUMNS); c++) a_q[r][c] <= '0;
                for (int c = 0; c < int'(BCOLUMNS); c++) MatrixO[r][c] <= '0;
            end
            for (int r = 0; r < int'(ACOLUMNS); r++)
                for (int c = 0; c < int'(BCOLUMNS); c++) b_q[r][c] <= '0;
            accum_q    <= 1'b0;
            sat_q      <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            elem_valid <= 1'b0;
            elem_row   <= '0;
            elem_col   <= '0;
            elem_data  <= '0;
            overflow   <= 1'b0;
        end else if (ena) begin
            done       <= 1'b0;
            elem_valid <= 1'b0;
            if (start_fire_c) begin
                a_q      <= MatrixA;
                b_q      <= MatrixB;
                accum_q  <= accumulate;
                sat_q    <= sat_mode;
                overflow <= 1'b0;
                i_q      <= '0;
                j_q      <= '0;
                k_q      <= '0;
                acc_q    <= '0;
                busy     <= 1'b1;
            end else if (state_q == RUN) begin
                if (!last_k_c) begin
                    acc_q <= acc_next_c;
                    k_q   <= k_q + K_W'(1);
                end else begin
                    MatrixO[i_q][j_q] <= elem_c;
                    elem_data  <= elem_c;
                    elem_valid <= 1'b1;
                    elem_row   <= i_q;
                    elem_col   <= j_q;
                    overflow   <= overflow | ovf_c;
                    acc_q      <= '0;
                    k_q        <= '0;
                    if (last_j_c) begin
                        j_q <= '0;
                        i_q <= (i_q == ROW_W'(AROWS - 1)) ? '0 : i_q + ROW_W'(1);
                    end else begin
                        j_q <= j_q + COL_W'(1);
                    end
                    if (last_elem_c) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Scoreboard bench for matrix_mult_seq (3x3x3, 8-bit elements): directed runs with
// hand-computed results; a negedge monitor pops expected elements as they stream out.
module tb_matrix_mult_seq;

    localparam int unsigned N = 27;

    typedef logic signed [7:0] mat_t [3][3];
    typedef struct { int row; int col; int data; } exp_t;

    logic clock = 1'b0;
    logic nreset, ena, start, accumulate, sat_mode;
    mat_t mat_a, mat_b, mat_o;
    logic busy, done, elem_valid, overflow;
    logic [1:0] elem_row, elem_col;
    logic signed [7:0] elem_data;

    matrix_mult_seq #(.AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .WIDTH_BIT(8)) dut (
        .clock(clock), .nreset(nreset), .ena(ena), .start(start),
        .accumulate(accumulate), .sat_mode(sat_mode),
        .MatrixA(mat_a), .MatrixB(mat_b), .MatrixO(mat_o),
        .busy(busy), .done(done), .elem_valid(elem_valid),
        .elem_row(elem_row), .elem_col(elem_col), .elem_data(elem_data),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic ena_at_edge = 1'b1;
    int   busy_cnt, first_busy, done_cnt, done_cyc;
    exp_t q [$];

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        ena_at_edge <= ena;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: a pulse held through a stall is a single event, so only count it when freshly produced
    always @(negedge clock) begin
        if (nreset) begin
            if (busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (elem_valid && ena_at_edge) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL elem_unexpected: got element (%0d,%0d)=%0d, expected none",
                             elem_row, elem_col, elem_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("elem_row", elem_row, e.row);
                    check("elem_col", elem_col, e.col);
                    check($sformatf("elem_data[%0d][%0d]", e.row, e.col), elem_data, e.data);
                end
            end
            if (done && ena_at_edge) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    mat_t m_zero = '{'{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
    mat_t m_id   = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mat_t m_nid  = '{'{-1, 0, 0}, '{0, -1, 0}, '{0, 0, -1}};
    mat_t m_b    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mat_t m_2b   = '{'{2, 4, 6}, '{8, 10, 12}, '{14, 16, 18}};
    mat_t m_nb   = '{'{-1, -2, -3}, '{-4, -5, -6}, '{-7, -8, -9}};
    mat_t m_100  = '{'{100, 100, 100}, '{100, 100, 100}, '{100, 100, 100}};
    mat_t m_127  = '{'{127, 127, 127}, '{127, 127, 127}, '{127, 127, 127}};
    mat_t m_48   = '{'{48, 48, 48}, '{48, 48, 48}, '{48, 48, 48}};

    task automatic run_mult(input string tag, input mat_t a, input mat_t b, input mat_t exp_o,
                            input logic acc, input logic sat, input logic exp_ovf,
                            input int stall_after, input logic poke);
        int waited;
        int extra;
        extra = (stall_after >= 0) ? 4 : 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                q.push_back('{i, j, int'(exp_o[i][j])});
        busy_cnt   = 0;
        first_busy = -1;
        done_cnt   = 0;
        mat_a = a; mat_b = b; accumulate = acc; sat_mode = sat; start = 1'b1;
        tick();
        start = 1'b0;
        mat_a = m_zero; mat_b = m_zero; accumulate = ~acc; sat_mode = ~sat;
        if (poke) begin
            repeat (3) tick();
            mat_a = m_100;
            start = 1'b1;
            repeat (2) tick();
            start = 1'b0;
        end
        if (stall_after >= 0) begin
            repeat (stall_after) tick();
            ena = 1'b0;
            repeat (4) tick();
            ena = 1'b1;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 200) begin
            tick();
            waited++;
        end
        if (done_cnt == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s done_timeout: got no done in %0d cycles, expected one", tag, waited);
        end
        tick();
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, N + extra);
        check({tag, " done_latency"}, done_cyc - first_busy, N + extra);
        check({tag, " elems_left"}, q.size(), 0);
        check({tag, " overflow"}, overflow, exp_ovf);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("%s O[%0d][%0d]", tag, i, j), mat_o[i][j], exp_o[i][j]);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset = 1'b0; ena = 1'b1; start = 1'b0; accumulate = 1'b0; sat_mode = 1'b0;
        mat_a = m_zero; mat_b = m_zero;
        busy_cnt = 0; first_busy = -1; done_cnt = 0; done_cyc = 0;
        repeat (3) tick();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset elem_valid", elem_valid, 0);
        check("reset overflow", overflow, 0);
        check("reset elem_data", elem_data, 0);
        check("reset O[2][2]", mat_o[2][2], 0);
        nreset = 1'b1;
        tick();

        run_mult("identity", m_id,  m_b,   m_b,   1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_mult("accum",    m_id,  m_b,   m_2b,  1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_mult("sat",      m_100, m_100, m_127, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        run_mult("wrap",     m_100, m_100, m_48,  1'b0, 1'b0, 1'b1, -1, 1'b0);
        run_mult("negative", m_nid, m_b,   m_nb,  1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_mult("stall",    m_id,  m_b,   m_b,   1'b0, 1'b0, 1'b0, 10, 1'b0);

        // Abort: reset ten cycles into a run; three elements have streamed by then
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                q.push_back('{i, j, int'(m_nb[i][j])});
        done_cnt = 0;
        mat_a = m_nid; mat_b = m_b; accumulate = 1'b0; sat_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        nreset = 1'b0;
        #1;
        check("abort elems_left", q.size(), 6);
        check("abort busy", busy, 0);
        tick();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check($sformatf("abort O[%0d][%0d]", i, j), mat_o[i][j], 0);
        q.delete();
        nreset = 1'b1;
        repeat (8) tick();
        check("abort done_count", done_cnt, 0);
        check("abort busy_after", busy, 0);

        run_mult("recover",  m_id,  m_b,   m_b,   1'b0, 1'b0, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
Sequential signed matrix multiplier, O = A×B or O = O + A×B. One multiply-accumulate (MAC) per enabled cycle, driven by a start/busy/done handshake.
- Inputs are snapshotted at start; the caller may change them afterwards.
- Accumulator width is configurable; results are saturated or wrapped to WIDTH_BIT, with a sticky overflow flag.
- Each finished element is also streamed out with its row/column index.
- Sits in the ConvNet datapath as the generalised successor of the fixed, free-running multiplier.

Parameters:
AROWS, 3, rows of A and O
ACOLUMNS, 3, columns of A = rows of B (inner dimension K)
BCOLUMNS, 3, columns of B and O
WIDTH_BIT, 32, signed element width of A, B, O
ACC_WIDTH, 2*WIDTH_BIT+$clog2(ACOLUMNS)+1, signed accumulator width (must be ≥ 2*WIDTH_BIT+1)

Ports:
clock  in  1  rising-edge clock
nreset  in  1  asynchronous active-low reset
ena  in  1  clock enable; low freezes all state except reset
start  in  1  request a new product; sampled only in IDLE while ena=1
accumulate  in  1  captured at start; 1 → O += A×B, 0 → O = A×B
sat_mode  in  1  captured at start; 1 → saturate, 0 → wrap (keep low WIDTH_BIT bits)
MatrixA  in  signed [WIDTH_BIT-1:0] [AROWS][ACOLUMNS]  operand A
MatrixB  in  signed [WIDTH_BIT-1:0] [ACOLUMNS][BCOLUMNS]  operand B
MatrixO  out  signed [WIDTH_BIT-1:0] [AROWS][BCOLUMNS]  result registers
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse when the last element is written
elem_valid  out  1  one-cycle pulse per finished element
elem_row  out  $clog2(AROWS) (min 1)  row of the streamed element
elem_col  out  $clog2(BCOLUMNS) (min 1)  column of the streamed element
elem_data  out  signed [WIDTH_BIT-1:0]  streamed element value (post saturate/wrap)
overflow  out  1  sticky: any element of the current run exceeded WIDTH_BIT range

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE; i=j=k=0; accumulator=0.
  - MatrixO all 0; busy, done, elem_valid, overflow = 0; elem_row, elem_col, elem_data = 0.
  - Reset mid-run aborts immediately; no partial completion signalled.
- States: IDLE, RUN, DONE.
- IDLE:
  - On ena=1 and start=1: register MatrixA, MatrixB, accumulate, sat_mode; clear overflow; i=j=k=0, acc=0.
  - Next state RUN; busy=1 from the next cycle.
- RUN, each ena=1 cycle:
  - acc_next = acc + sext(A[i][k]) * sext(B[k][j]), computed in ACC_WIDTH.
  - If k<ACOLUMNS-1: acc ← acc_next; k++.
  - If k==ACOLUMNS-1:
    - r = acc_next + (accumulate ? sext(MatrixO[i][j]) : 0).
    - If r is out of [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1], set overflow.
    - Element value = sat_mode ? clamp(r) : r[WIDTH_BIT-1:0].
    - The value is written to MatrixO[i][j] and to elem_data in the next cycle, with elem_valid=1 and elem_row=i, elem_col=j.
    - acc ← 0; k ← 0. Advance j; on wrap of j, advance i.
    - Iteration order is row-major: j is the fast index, then i.
  - After the element (AROWS-1, BCOLUMNS-1) is issued: next state DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next state IDLE.
- Latency: with start accepted at edge t and ena held at 1:
  - busy is high for cycles t+1 … t+N, where N = AROWS*BCOLUMNS*ACOLUMNS.
  - done is high at cycle t+N+1.
  - A new start is accepted at t+N+2 at the earliest.
- ena=0 in any state: hold all registers. Pulse outputs (done, elem_valid) stay high while stalled and count as one event.
- start outside IDLE, or while ena=0, is ignored.
- MatrixO holds its values between runs. Elements not yet rewritten in the current run keep their previous values.
- ACOLUMNS=1: every RUN cycle completes an element.
- Degenerate 1×1×1: N=1.

Test Plan:
- Identity: A=I(3×3), B=[[1,2,3],[4,5,6],[7,8,9]], accumulate=0, start at cycle 5 → busy cycles 6–32, done at 33, MatrixO=B, 9 elem_valid pulses in row-major order, overflow=0.
- Accumulate: repeat the identity run with accumulate=1 → MatrixO=2·B, e.g. O[2][2]=18.
- Saturation: WIDTH_BIT=8, A=B=all 100, sat_mode=1 → each r=30000 → all O=127, overflow=1. Same with sat_mode=0 → all O=48 (30000 mod 256), overflow=1.
- Negative values: A=[[-1,0,0],[0,-1,0],[0,0,-1]], B as in the identity test → O=-B, e.g. O[1][2]=-6.
- Stall and abort:
  - Drop ena for 4 cycles mid-RUN → result unchanged, done delayed by exactly 4 cycles.
  - Pulse nreset low mid-RUN → MatrixO=0, busy=0, no done pulse.
  - start asserted while busy is ignored.
